// File: rtl/bin_to_bcd4.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding
// the 4-digit 7-segment driver; results above 9999 are presented as "EEEE".
module bin_to_bcd4 #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       dp,
    output logic [15:0]      hexx,
    output logic [3:0]       points,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);
    localparam bit         CHECK_OVF = (WIDTH >= 14);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_shift;
    logic [15:0]      bcd_reg;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_shift;
    logic [4:0]       iter;
    logic [3:0]       dp_reg;
    logic [31:0]      value_ext;
    logic             too_big;
    logic             last_iter;

    // Narrow widths cannot represent anything above 9999, so the compare folds away.
    assign value_ext = 32'(value);
    assign too_big   = CHECK_OVF && (value_ext > 32'd9999);
    assign last_iter = (iter == LAST_ITER);

    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < 4; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top BCD bit is dropped; it is always zero for legal (<= 9999) values.
    assign {bcd_shift, bin_shift} = {bcd_adj[14:0], bin_reg, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = too_big ? DONE : CONVERT;
                end
            end
            CONVERT: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONVERT);
        done = (state == DONE);
    end

    // Display-facing registers only move on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            iter     <= '0;
            dp_reg   <= '0;
            hexx     <= '0;
            points   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (too_big) begin
                            hexx     <= 16'hEEEE;
                            points   <= 4'b1111;
                            overflow <= 1'b1;
                        end else begin
                            bin_reg <= value;
                            dp_reg  <= dp;
                            bcd_reg <= '0;
                            iter    <= '0;
                        end
                    end
                end
                CONVERT: begin
                    bcd_reg <= bcd_shift;
                    bin_reg <= bin_shift;
                    iter    <= iter + 5'd1;
                    if (last_iter) begin
                        hexx     <= bcd_shift;
                        points   <= dp_reg;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
